// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic multiplier.
// Provides the FSM state type, the default geometry and the width helpers
// used by the interface, the top level and the testbench.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Accumulator must hold SIZE products of two WIDTH-bit operands.
    function automatic int acc_width(input int width, input int size);
        return 2 * width + $clog2(size);
    endfunction

    // Counter spans 0..3*SIZE-3 during RUN.
    function automatic int cnt_width(input int size);
        return $clog2(3 * size - 1);
    endfunction

    localparam int SA_WIDTH = 4;
    localparam int SA_SIZE  = 3;
    localparam int SA_CNT_W = $clog2(3 * SA_SIZE - 1);

endpackage

// File: rtl/systolic_array_if.sv
// Bus between the skew stages / result consumer and the systolic array.
//   master : drives start_i and the skewed lanes, observes results
//   slave  : the systolic array itself
// Signals:
//   start_i    begin a multiply (same pulse as the skew stages' valid_i)
//   a_skew_i   SIZE lanes of WIDTH bits, lane k feeds row k
//   b_skew_i   SIZE lanes of WIDTH bits, lane k feeds column k
//   c_o        C(i,j) at [(i*SIZE+j)*ACC_W +: ACC_W]
//   busy_o     high in RUN and DONE
//   done_o     one-cycle pulse when C is final
//   c_valid_o  high from DONE until the next accepted start or reset
interface systolic_array_if
    import systolic_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE,
    parameter int ACC_W = acc_width(SA_WIDTH, SA_SIZE)
);
    logic                        start_i;
    logic [SIZE*WIDTH-1:0]       a_skew_i;
    logic [SIZE*WIDTH-1:0]       b_skew_i;
    logic [SIZE*SIZE*ACC_W-1:0]  c_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        c_valid_o;

    modport master (
        output start_i, a_skew_i, b_skew_i,
        input  c_o, busy_o, done_o, c_valid_o
    );

    modport slave (
        input  start_i, a_skew_i, b_skew_i,
        output c_o, busy_o, done_o, c_valid_o
    );
endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate processing element of the systolic grid.
// Ports:
//   clock, nreset   rising-edge clock, async active-low reset
//   clr_i           clear accumulator and forwarding regs (start of a multiply)
//   en_i            advance: forward operands and accumulate a_i*b_i
//   a_i, b_i        operands from the left / from above
//   a_o, b_o        registered operands forwarded right / down
//   acc_o           accumulated dot-product element
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int ACC_W = acc_width(SA_WIDTH, SA_SIZE)
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [ACC_W-1:0] acc_o
);
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0] prod_s;

    // Next-state: clear on start, otherwise forward and accumulate while enabled.
    always_comb begin
        prod_s = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (clr_i) begin
            a_d   = {WIDTH{1'b0}};
            b_d   = {WIDTH{1'b0}};
            acc_d = {ACC_W{1'b0}};
        end else if (en_i) begin
            a_d   = a_i;
            b_d   = b_i;
            // Modulo 2^ACC_W: overflow wraps silently.
            acc_d = acc_q + ACC_W'(prod_s);
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            acc_q <= {ACC_W{1'b0}};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
endmodule

// File: rtl/systolic_array.sv
// SIZE x SIZE output-stationary systolic matrix multiplier, C = A*B.
// Rows take skewed A from the left edge, columns take skewed B from the
// top edge; each PE accumulates its own C element. A fixed-length RUN
// window is followed by a one-cycle DONE with done_o, after which C is
// held with c_valid_o until the next accepted start.
// Ports:
//   clock, nreset   rising-edge clock, async active-low reset
//   bus             systolic_array_if slave (start, skewed lanes, results)
module systolic_array
    import systolic_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE,
    parameter int ACC_W = acc_width(SA_WIDTH, SA_SIZE)
) (
    input  logic              clock,
    input  logic              nreset,
    systolic_array_if.slave   bus
);
    localparam int               CNT_W    = cnt_width(SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(3 * SIZE - 3);
    // The upstream skew stages deliver 2*SIZE-1 vectors.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(2 * SIZE - 2);

    sa_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             clr_s, en_s, in_win_s;

    logic [WIDTH-1:0] a_edge_s [SIZE];
    logic [WIDTH-1:0] b_edge_s [SIZE];
    logic [WIDTH-1:0] a_fwd_s  [SIZE][SIZE];
    logic [WIDTH-1:0] b_fwd_s  [SIZE][SIZE];
    logic [ACC_W-1:0] acc_s    [SIZE][SIZE];
    logic [SIZE-1:0]  fwd_unused_s;

    // FSM next-state, counter and PE control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        clr_s   = 1'b0;
        en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    cnt_d   = {CNT_W{1'b0}};
                    clr_s   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                en_s = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = {CNT_W{1'b0}};
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // start_i here is ignored; it is accepted one cycle later in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == RUN) || (state_d == DONE);
    end

    // Edge gating: past the input window the grid edges see zeros.
    always_comb begin
        in_win_s = (cnt_q <= WIN_LAST);
        for (int k = 0; k < SIZE; k++) begin
            a_edge_s[k] = in_win_s ? bus.a_skew_i[k*WIDTH +: WIDTH] : {WIDTH{1'b0}};
            b_edge_s[k] = in_win_s ? bus.b_skew_i[k*WIDTH +: WIDTH] : {WIDTH{1'b0}};
        end
    end

    // Control registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_col
            logic [WIDTH-1:0] a_in_s;
            logic [WIDTH-1:0] b_in_s;
            if (j == 0) begin : g_left
                assign a_in_s = a_edge_s[i];
            end else begin : g_inner_a
                assign a_in_s = a_fwd_s[i][j-1];
            end
            if (i == 0) begin : g_top
                assign b_in_s = b_edge_s[j];
            end else begin : g_inner_b
                assign b_in_s = b_fwd_s[i-1][j];
            end
            systolic_pe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_pe (
                .clock  (clock),
                .nreset (nreset),
                .clr_i  (clr_s),
                .en_i   (en_s),
                .a_i    (a_in_s),
                .b_i    (b_in_s),
                .a_o    (a_fwd_s[i][j]),
                .b_o    (b_fwd_s[i][j]),
                .acc_o  (acc_s[i][j])
            );
            assign bus.c_o[(i*SIZE+j)*ACC_W +: ACC_W] = acc_s[i][j];
        end
        // Operands leaving the right column / bottom row go nowhere.
        assign fwd_unused_s[i] = ^{a_fwd_s[i][SIZE-1], b_fwd_s[SIZE-1][i]};
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.c_valid_o = valid_q;
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array (SIZE=3, WIDTH=4).
// Emulates the two upstream skew stages: during RUN cycle t, row lane i
// carries A[i][t-i] and column lane j carries B[t-j][j] (zero outside the
// matrix). Lanes carry random junk outside the input window. Expected C
// values are pushed to a scoreboard at start and popped at done_o.
module tb_systolic_array;
    import systolic_pkg::*;

    localparam int W  = 4;
    localparam int S  = 3;
    localparam int AW = acc_width(W, S);
    localparam int CW = S * S * AW;

    typedef logic [CW-1:0]  cvec_t;
    typedef logic [S*W-1:0] lane_t;
    typedef struct {
        int a[S][S];
        int b[S][S];
        int c[S][S];
        bit glitch;
    } vec_t;

    logic  clock  = 1'b0;
    logic  nreset = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    ma[S][S];
    int    mb[S][S];
    int    eye[S][S];
    int    eye2[S][S];
    cvec_t sb[$];
    cvec_t last_c;
    vec_t  tbl[4];

    always #5 clock = ~clock;

    systolic_array_if #(.WIDTH(W), .SIZE(S), .ACC_W(AW)) bus ();

    systolic_array #(.WIDTH(W), .SIZE(S), .ACC_W(AW)) dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkc(input string name, input cvec_t act, input cvec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cvec_t pack(input int m[S][S]);
        cvec_t r = '0;
        int v;
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                v = m[i][j];
                r[(i*S+j)*AW +: AW] = v[AW-1:0];
            end
        return r;
    endfunction

    // Reference C = A*B from the current operand matrices.
    function automatic cvec_t model();
        int m[S][S];
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                m[i][j] = 0;
                for (int k = 0; k < S; k++) m[i][j] += ma[i][k] * mb[k][j];
                m[i][j] = m[i][j] % (1 << AW);
            end
        return pack(m);
    endfunction

    task automatic drive_junk();
        bus.a_skew_i = lane_t'($urandom);
        bus.b_skew_i = lane_t'($urandom);
    endtask

    task automatic drive_vec(input int t);
        lane_t av = '0;
        lane_t bv = '0;
        int k;
        if (t > 2*S-2) begin
            drive_junk();
        end else begin
            for (int i = 0; i < S; i++) begin
                k = t - i;
                if (k >= 0 && k < S) begin
                    av[i*W +: W] = W'(ma[i][k]);
                    bv[i*W +: W] = W'(mb[k][i]);
                end
            end
            bus.a_skew_i = av;
            bus.b_skew_i = bv;
        end
    endtask

    // Full multiply: start cycle, 3*S-2 RUN cycles, DONE cycle.
    task automatic run_mult(input bit glitch);
        cvec_t exp;
        @(negedge clock);
        check1("idle_busy", bus.busy_o, 1'b0);
        check1("idle_done", bus.done_o, 1'b0);
        bus.start_i = 1'b1;
        drive_junk();
        for (int t = 0; t < 3*S-2; t++) begin
            @(negedge clock);
            check1($sformatf("run%0d_busy", t), bus.busy_o, 1'b1);
            check1($sformatf("run%0d_done", t), bus.done_o, 1'b0);
            check1($sformatf("run%0d_cvalid", t), bus.c_valid_o, 1'b0);
            bus.start_i = glitch && (t == 3);
            drive_vec(t);
        end
        @(negedge clock);
        bus.start_i = 1'b0;
        drive_junk();
        check1("done_pulse", bus.done_o, 1'b1);
        check1("done_busy", bus.busy_o, 1'b1);
        check1("done_cvalid", bus.c_valid_o, 1'b1);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got done_o with no expected result");
        end else begin
            exp = sb.pop_front();
            checkc("c_result", bus.c_o, exp);
            last_c = exp;
        end
    endtask

    task automatic hold_check(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clock);
            drive_junk();
            checkc($sformatf("hold%0d_c", t), bus.c_o, last_c);
            check1($sformatf("hold%0d_cvalid", t), bus.c_valid_o, 1'b1);
            check1($sformatf("hold%0d_busy", t), bus.busy_o, 1'b0);
        end
    endtask

    task automatic abort_run();
        int done_seen = 0;
        @(negedge clock);
        bus.start_i = 1'b1;
        drive_junk();
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            bus.start_i = 1'b0;
            drive_vec(t);
        end
        // RUN cycle 4: pull reset mid-cycle.
        nreset = 1'b0;
        #1;
        checkc("abort_c", bus.c_o, '0);
        check1("abort_busy", bus.busy_o, 1'b0);
        check1("abort_done", bus.done_o, 1'b0);
        check1("abort_cvalid", bus.c_valid_o, 1'b0);
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clock);
            drive_junk();
            if (bus.done_o === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", done_seen);
        end
        check1("abort_idle_busy", bus.busy_o, 1'b0);
    endtask

    initial begin
        tbl[0].a = '{'{1,2,3}, '{7,6,5}, '{8,9,4}};
        tbl[0].b = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
        tbl[0].c = '{'{1,2,3}, '{7,6,5}, '{8,9,4}};
        tbl[0].glitch = 1'b0;
        tbl[1].a = '{'{15,15,15}, '{15,15,15}, '{15,15,15}};
        tbl[1].b = '{'{15,15,15}, '{15,15,15}, '{15,15,15}};
        tbl[1].c = '{'{675,675,675}, '{675,675,675}, '{675,675,675}};
        tbl[1].glitch = 1'b0;
        tbl[2].a = '{'{1,2,3}, '{4,5,6}, '{7,8,9}};
        tbl[2].b = '{'{1,2,3}, '{4,5,6}, '{7,8,9}};
        tbl[2].c = '{'{30,36,42}, '{66,81,96}, '{102,126,150}};
        tbl[2].glitch = 1'b0;
        tbl[3] = tbl[0];
        tbl[3].glitch = 1'b1;
        eye  = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
        eye2 = '{'{2,0,0}, '{0,2,0}, '{0,0,2}};

        bus.start_i  = 1'b0;
        bus.a_skew_i = '0;
        bus.b_skew_i = '0;
        nreset = 1'b0;
        repeat (3) @(negedge clock);
        checkc("rst_c", bus.c_o, '0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check1("rst_done", bus.done_o, 1'b0);
        check1("rst_cvalid", bus.c_valid_o, 1'b0);
        nreset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            ma = tbl[i].a;
            mb = tbl[i].b;
            sb.push_back(pack(tbl[i].c));
            run_mult(tbl[i].glitch);
            if (i == 1) hold_check(20);
        end

        // Reset mid-RUN, then a fresh multiply must still be correct.
        ma = tbl[2].a;
        mb = tbl[2].b;
        abort_run();
        sb.push_back(pack(tbl[2].c));
        run_mult(1'b0);

        // Back-to-back: start in the cycle right after done_o.
        ma = eye;
        mb = eye2;
        sb.push_back(pack(eye2));
        run_mult(1'b0);

        // Random operands against the reference model.
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++) begin
                ma[i][j] = int'($urandom_range(15, 0));
                mb[i][j] = int'($urandom_range(15, 0));
            end
        sb.push_back(model());
        run_mult(1'b0);

        @(negedge clock);
        check1("end_done", bus.done_o, 1'b0);
        check1("end_busy", bus.busy_o, 1'b0);
        check1("end_cvalid", bus.c_valid_o, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
